md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit for the 5-stage MIPS pipeline. Sits in the E stage.
- Sequences multi-cycle mult/multu/div/divu operations, owns the HI/LO registers and handles mthi/mtlo writes.
- Drives the busy signal that the hazard controller combines with start to stall D.
- Supports cancellation of an issuing instruction on exception/interrupt flush.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- start  input  1  E-stage instruction is an md-unit operation this cycle.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- flush  input  1  exception/interrupt cancels the E-stage instruction this cycle.
- rd_sel  input  1  0 selects LO, 1 selects HI for mflo/mfhi read.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- rd_data  output  32  combinational: rd_sel ? hi : lo.

Behaviour:
- Reset values: busy=0, hi=0, lo=0, counter=0, state IDLE, pending result regs=0.
- Valid issue = start & !flush & op in 1..6 & state==IDLE. All other start events are ignored with no state change, including start while BUSY; the hazard controller guarantees BUSY issue never occurs.
- States: IDLE, BUSY.
- IDLE -> BUSY on valid issue of op 1..4.
  - Compute the result in the issue cycle and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
- BUSY behaviour:
  - busy=1.
  - Counter decrements each cycle.
  - When counter==1: at that edge commit pending to hi/lo, clear busy, and return to IDLE.
- Timing: an issue in cycle t gives busy=1 for cycles t+1..t+N. The new hi/lo are visible from cycle t+N+1. The unit does not assert busy in cycle t; the controller stalls on start.
- mthi/mtlo (op 5,6) on valid issue: write a to hi or lo at the next edge. The other register is unchanged. State stays IDLE and busy stays 0.
- Arithmetic:
  - mult: signed 32x32 -> 64, {hi,lo}=product.
  - multu: the same operation, unsigned.
  - div: lo=signed quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: the same operation, unsigned.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b==0): normal busy latency, hi/lo unchanged at commit.
- flush in the issue cycle fully cancels the issue: no busy, no hi/lo change.
- flush while BUSY does not abort. The in-flight instruction already committed past E and runs to completion.
- reset mid-operation: next edge returns all state to reset values and drops the pending result.
- rd_data reflects current hi/lo. It does not bypass a pending result; the controller stalls mfhi/mflo while start|busy.

Test Plan:
- reset; start op=1 a=0xFFFFFFFE(-2) b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- start op=3 a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7 b=2 -> lo=3, hi=1; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preset hi=0x11, lo=0x22 via mthi/mtlo, then div b=0 -> busy 10 cycles, hi=0x11, lo=0x22 afterwards.
- start op=1 with flush=1 same cycle -> busy stays 0, hi/lo unchanged. Separately, flush asserted on cycle 2 of a busy mult -> mult still completes at cycle 5 with the correct result.
- start op=4 during BUSY of a prior mult -> ignored; only the mult commits and busy falls after 5 cycles. mthi a=0xDEADBEEF while IDLE -> hi=0xDEADBEEF next cycle, rd_sel=1 gives rd_data=0xDEADBEEF.
- reset asserted on cycle 3 of a div -> next cycle busy=0, hi=lo=0, and no later commit occurs.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS E-stage multiply/divide unit owning HI/LO.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [31:0]   pending_hi, pending_lo;
  logic          pending_we;

  logic          issue, is_mul, is_div, signed_op;
  logic [63:0]   ext_a, ext_b, prod;
  logic          neg_a, neg_b;
  logic [31:0]   div_a, div_b, div_b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    issue     = start && !flush && (state == IDLE) && (op >= 3'd1) && (op <= 3'd6);
    is_mul    = (op == 3'd1) || (op == 3'd2);
    is_div    = (op == 3'd3) || (op == 3'd4);
    signed_op = (op == 3'd1) || (op == 3'd3);

    // Truncated 64x64 product of extended operands is exact for both signednesses.
    ext_a = {{32{signed_op & a[31]}}, a};
    ext_b = {{32{signed_op & b[31]}}, b};
    prod  = ext_a * ext_b;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    neg_a      = signed_op && a[31];
    neg_b      = signed_op && b[31];
    div_a      = neg_a ? -a : a;
    div_b      = neg_b ? -b : b;
    div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
    q_mag      = div_a / div_b_safe;
    r_mag      = div_a % div_b_safe;
    quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem        = neg_a ? -r_mag : r_mag;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue && (is_mul || is_div)) state_next = BUSY;
      BUSY: if (count == CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      pending_we <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else if (state == IDLE) begin
      if (issue) begin
        if (is_mul) begin
          pending_hi <= prod[63:32];
          pending_lo <= prod[31:0];
          pending_we <= 1'b1;
          count      <= CW'(MULT_CYCLES);
        end else if (is_div) begin
          pending_hi <= rem;
          pending_lo <= quot;
          pending_we <= (b != 32'd0);
          count      <= CW'(DIV_CYCLES);
        end else if (op == 3'd5) begin
          hi <= a;
        end else begin
          lo <= a;
        end
      end
    end else begin
      count <= count - CW'(1);
      if ((count == CW'(1)) && pending_we) begin
        hi <= pending_hi;
        lo <= pending_lo;
      end
    end
  end

  assign busy    = (state == BUSY);
  assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit with directed vectors.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        rd_sel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .rd_sel(rd_sel), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    bit          now;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   run_len = 0;
  bit   prev_busy = 1'b0;
  bit   chk_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: a busy falling edge is a commit; chk_req marks an idle-state sample point.
  always @(negedge clk) begin
    if (busy) run_len++;
    if (!busy && prev_busy) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_commit: got hi=%08h lo=%08h expected no commit", hi, lo);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_kind"}, {31'd0, e.now}, 32'd0);
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_busy_len"}, run_len, e.len);
      end
      run_len = 0;
    end
    if (chk_req) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL empty_scoreboard: got sample request expected queued entry");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_rd_data"}, rd_data, rd_sel ? e.hi : e.lo);
      end
    end
    if (reset) run_len = 0;
    prev_busy = reset ? 1'b0 : busy;
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic f);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; flush = f;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; flush = 1'b0;
  endtask

  task automatic expect_commit(input string nm, input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t t;
    t.name = nm; t.hi = h; t.lo = l; t.len = n; t.now = 1'b0;
    sb.push_back(t);
  endtask

  task automatic check_now(input string nm, input logic [31:0] h, input logic [31:0] l);
    exp_t t;
    t.name = nm; t.hi = h; t.lo = l; t.len = 0; t.now = 1'b1;
    sb.push_back(t);
    @(posedge clk); #1;
    chk_req = 1'b1;
    @(negedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles expected busy=0", nm, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_now("reset", 32'h0, 32'h0);

    expect_commit("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle("mult");

    expect_commit("multu", 32'h00000002, 32'hFFFFFFFA, 5);
    issue(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle("multu");

    expect_commit("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle("div");

    expect_commit("divu", 32'd1, 32'd3, 10);
    issue(3'd4, 32'd7, 32'd2, 1'b0);
    wait_idle("divu");

    expect_commit("div_ovf", 32'h0, 32'h80000000, 10);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle("div_ovf");

    issue(3'd5, 32'h11, 32'd0, 1'b0);
    check_now("mthi", 32'h11, 32'h80000000);
    issue(3'd6, 32'h22, 32'd0, 1'b0);
    check_now("mtlo", 32'h11, 32'h22);

    expect_commit("div_zero", 32'h11, 32'h22, 10);
    issue(3'd3, 32'd5, 32'd0, 1'b0);
    wait_idle("div_zero");

    issue(3'd1, 32'd2, 32'd3, 1'b1);
    check_now("flush_issue", 32'h11, 32'h22);

    expect_commit("flush_busy", 32'h1, 32'h0, 5);
    issue(3'd1, 32'h00010000, 32'h00010000, 1'b0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle("flush_busy");

    expect_commit("start_in_busy", 32'h0, 32'd42, 5);
    issue(3'd1, 32'd7, 32'd6, 1'b0);
    start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0; op = 3'd0;
    wait_idle("start_in_busy");
    repeat (12) @(posedge clk);
    check_now("no_late_divu", 32'h0, 32'd42);

    issue(3'd5, 32'hDEADBEEF, 32'd0, 1'b0);
    rd_sel = 1'b1;
    check_now("mthi_rd_hi", 32'hDEADBEEF, 32'd42);
    rd_sel = 1'b0;
    check_now("rd_lo", 32'hDEADBEEF, 32'd42);

    issue(3'd3, 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_now("reset_mid", 32'h0, 32'h0);
    repeat (15) @(posedge clk);
    check_now("reset_no_commit", 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
